// File: rtl/div_rr_scheduler_if.sv
// Request/response bundle between the two requesters and the shared divide engine.
interface div_rr_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       req;
    logic [WIDTH-1:0] dividend0;
    logic [WIDTH-1:0] dividend1;
    logic [WIDTH-1:0] divisor0;
    logic [WIDTH-1:0] divisor1;
    logic [1:0]       ack;
    logic             busy;
    logic [1:0]       resp_valid;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    modport master (
        output req, dividend0, dividend1, divisor0, divisor1,
        input  ack, busy, resp_valid, q, r, div_by_zero
    );

    modport slave (
        input  req, dividend0, dividend1, divisor0, divisor1,
        output ack, busy, resp_valid, q, r, div_by_zero
    );
endinterface

// File: rtl/div_rr_scheduler.sv
// Round-robin shared signed divider: restoring division, one quotient bit per cycle,
// truncating quotient and dividend-signed remainder returned to the granted requester.
module div_rr_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    div_rr_scheduler_if.slave bus
);
    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state, w_state_nxt;

    logic             r_last_grant, w_last_grant_nxt;
    logic             r_grant, w_grant_nxt;
    logic             r_sign_q, w_sign_q_nxt;
    logic             r_sign_r, w_sign_r_nxt;
    logic             r_dbz, w_dbz_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [XW-1:0]    r_dvs, w_dvs_nxt;
    logic [XW-1:0]    r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [1:0]       r_ack, w_ack_nxt;
    logic [1:0]       r_resp_valid, w_resp_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_div_by_zero, w_div_by_zero_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_r, w_r_nxt;

    logic             w_any, w_pick;
    logic [WIDTH-1:0] w_dvd, w_dvs;
    logic [XW-1:0]    w_dvd_abs, w_dvs_abs;
    logic [XW-1:0]    w_part, w_diff;
    logic             w_ge;

    // Arbitration: a lone request wins outright, contention goes to the other side.
    always_comb begin
        w_any  = |bus.req;
        w_pick = (bus.req == 2'b11) ? ~r_last_grant : bus.req[1];
        w_dvd  = w_pick ? bus.dividend1 : bus.dividend0;
        w_dvs  = w_pick ? bus.divisor1  : bus.divisor0;
        w_dvd_abs = w_dvd[WIDTH-1] ? ({XW{1'b0}} - {w_dvd[WIDTH-1], w_dvd}) : {1'b0, w_dvd};
        w_dvs_abs = w_dvs[WIDTH-1] ? ({XW{1'b0}} - {w_dvs[WIDTH-1], w_dvs}) : {1'b0, w_dvs};
        w_part = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_diff = w_part - r_dvs;
        w_ge   = (w_part >= r_dvs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_state_nxt = (w_dvs == '0) ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_last_grant_nxt  = r_last_grant;
        w_grant_nxt       = r_grant;
        w_sign_q_nxt      = r_sign_q;
        w_sign_r_nxt      = r_sign_r;
        w_dbz_nxt         = r_dbz;
        w_cnt_nxt         = r_cnt;
        w_dvs_nxt         = r_dvs;
        w_rem_nxt         = r_rem;
        w_quo_nxt         = r_quo;
        w_ack_nxt         = 2'b00;
        w_resp_valid_nxt  = 2'b00;
        w_busy_nxt        = 1'b1;
        w_div_by_zero_nxt = r_div_by_zero;
        w_q_nxt           = r_q;
        w_r_nxt           = r_r;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = w_any;
                if (w_any) begin
                    w_ack_nxt        = w_pick ? 2'b10 : 2'b01;
                    w_last_grant_nxt = w_pick;
                    w_grant_nxt      = w_pick;
                    w_sign_q_nxt     = w_dvd[WIDTH-1] ^ w_dvs[WIDTH-1];
                    w_sign_r_nxt     = w_dvd[WIDTH-1];
                    w_dvs_nxt        = w_dvs_abs;
                    w_cnt_nxt        = CNT_W'(WIDTH);
                    // Zero divisor: park |dividend| as the remainder so FIX restores the dividend.
                    if (w_dvs == '0) begin
                        w_dbz_nxt = 1'b1;
                        w_rem_nxt = w_dvd_abs;
                        w_quo_nxt = '0;
                    end else begin
                        w_dbz_nxt = 1'b0;
                        w_rem_nxt = '0;
                        w_quo_nxt = w_dvd_abs[WIDTH-1:0];
                    end
                end
            end
            S_CALC: begin
                w_rem_nxt = w_ge ? w_diff : w_part;
                w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            S_FIX: begin
                w_q_nxt           = r_sign_q ? ({WIDTH{1'b0}} - r_quo) : r_quo;
                w_r_nxt           = WIDTH'(r_sign_r ? ({XW{1'b0}} - r_rem) : r_rem);
                w_div_by_zero_nxt = r_dbz;
            end
            S_DONE: w_resp_valid_nxt = r_grant ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dbz         <= 1'b0;
            r_cnt         <= '0;
            r_dvs         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_ack         <= 2'b00;
            r_resp_valid  <= 2'b00;
            r_busy        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_q           <= '0;
            r_r           <= '0;
        end else begin
            r_last_grant  <= w_last_grant_nxt;
            r_grant       <= w_grant_nxt;
            r_sign_q      <= w_sign_q_nxt;
            r_sign_r      <= w_sign_r_nxt;
            r_dbz         <= w_dbz_nxt;
            r_cnt         <= w_cnt_nxt;
            r_dvs         <= w_dvs_nxt;
            r_rem         <= w_rem_nxt;
            r_quo         <= w_quo_nxt;
            r_ack         <= w_ack_nxt;
            r_resp_valid  <= w_resp_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_div_by_zero <= w_div_by_zero_nxt;
            r_q           <= w_q_nxt;
            r_r           <= w_r_nxt;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.busy        = r_busy;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.q           = r_q;
    assign bus.r           = r_r;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: vector table plus hand sequences for contention and
// mid-operation reset; results checked against a scoreboard queue of expectations.
module tb_div_rr_scheduler;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;

    div_rr_scheduler_if #(.WIDTH(WIDTH)) bus ();

    div_rr_scheduler #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         req;
        logic               g;
        logic signed [31:0] dvd;
        logic signed [31:0] dvs;
        logic signed [31:0] eq;
        logic signed [31:0] er;
        logic               edbz;
    } vec_t;

    typedef struct {
        logic        g;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_resp = 2'b00;
    vec_t       tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: no DUT response within cycle budget", nm);
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_resp = 2'b00;
        end else begin
            if (bus.ack != 2'b00)
                chk("ack_while_busy", {31'b0, prev_busy && (prev_resp == 2'b00)}, 32'd0);
            if (bus.resp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {30'b0, bus.resp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valid", {30'b0, bus.resp_valid}, e.g ? 32'd2 : 32'd1);
                    chk("q", bus.q, e.q);
                    chk("r", bus.r, e.r);
                    chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
                end
            end
            prev_busy = bus.busy;
            prev_resp = bus.resp_valid;
        end
    end

    task automatic do_txn(input vec_t v);
        int lat;
        bit got;
        exp_t e;
        @(negedge clk);
        bus.dividend0 = v.g ? ~v.dvd : v.dvd;
        bus.divisor0  = v.g ? 32'h5a5a_0003 : v.dvs;
        bus.dividend1 = v.g ? v.dvd : ~v.dvd;
        bus.divisor1  = v.g ? v.dvs : 32'h5a5a_0003;
        bus.req       = v.req;
        e.g = v.g; e.q = v.eq; e.r = v.er; e.dbz = v.edbz;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = (bus.ack != 2'b00);
        end
        if (!got) begin
            timeout("ack_wait");
            bus.req = 2'b00;
            return;
        end
        chk("ack", {30'b0, bus.ack}, v.g ? 32'd2 : 32'd1);
        bus.req = 2'b00;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk);
            got = (bus.resp_valid != 2'b00);
            lat = k;
        end
        if (!got) begin
            timeout("resp_wait");
            return;
        end
        chk("latency", 32'(lat), v.edbz ? 32'd2 : 32'(WIDTH + 2));
        @(negedge clk);
        chk("q_hold", bus.q, v.eq);
        chk("r_hold", bus.r, v.er);
        chk("busy_after", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nack;
        int   nresp;
        bit   got;
        exp_t e;
        vec_t v;

        tbl[0]  = '{2'b01, 1'b0, 100, 7, 14, 2, 1'b0};
        tbl[1]  = '{2'b01, 1'b0, -100, 7, -14, -2, 1'b0};
        tbl[2]  = '{2'b10, 1'b1, 100, -7, -14, 2, 1'b0};
        tbl[3]  = '{2'b01, 1'b0, -100, -7, 14, -2, 1'b0};
        tbl[4]  = '{2'b10, 1'b1, 0, 5, 0, 0, 1'b0};
        tbl[5]  = '{2'b10, 1'b1, -55, 0, 0, -55, 1'b1};
        tbl[6]  = '{2'b01, 1'b0, 32'h8000_0000, -1, 32'h8000_0000, 0, 1'b0};
        tbl[7]  = '{2'b10, 1'b1, 32'h8000_0000, 3, -715827882, -2, 1'b0};
        tbl[8]  = '{2'b01, 1'b0, 7, 100, 0, 7, 1'b0};
        tbl[9]  = '{2'b10, 1'b1, 32'h7fff_ffff, 1, 32'h7fff_ffff, 0, 1'b0};
        tbl[10] = '{2'b01, 1'b0, -1, 32'h8000_0000, 0, -1, 1'b0};
        tbl[11] = '{2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 1, 0, 1'b0};
        tbl[12] = '{2'b10, 1'b1, 32'h8000_0000, 0, 0, 32'h8000_0000, 1'b1};
        tbl[13] = '{2'b01, 1'b0, 12345, -1, -12345, 0, 1'b0};
        tbl[14] = '{2'b10, 1'b1, 2147483647, -2147483647, -1, 0, 1'b0};
        tbl[15] = '{2'b01, 1'b0, -7, 2, -3, -1, 1'b0};

        rst_n         = 1'b0;
        bus.req       = 2'b00;
        bus.dividend0 = '0;
        bus.dividend1 = '0;
        bus.divisor0  = '0;
        bus.divisor1  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'b0, bus.ack}, 32'd0);
        chk("rst_resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_q", bus.q, 32'd0);
        chk("rst_r", bus.r, 32'd0);
        chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // Held contention: grants must alternate 0,1,0,1 starting from requester 0.
        @(negedge clk);
        bus.dividend0 = 32'sd1000;
        bus.divisor0  = 32'sd9;
        bus.dividend1 = -32'sd77;
        bus.divisor1  = 32'sd10;
        for (int i = 0; i < 4; i++) begin
            e.g   = i[0];
            e.q   = i[0] ? -32'sd7 : 32'sd111;
            e.r   = i[0] ? -32'sd7 : 32'sd1;
            e.dbz = 1'b0;
            sb.push_back(e);
        end
        bus.req = 2'b11;
        nack  = 0;
        nresp = 0;
        for (int k = 0; k < 400 && nresp < 4; k++) begin
            @(negedge clk);
            if (bus.ack != 2'b00) begin
                chk("rr_grant", {30'b0, bus.ack}, nack[0] ? 32'd2 : 32'd1);
                nack++;
                if (nack == 4) bus.req = 2'b00;
            end
            if (bus.resp_valid != 2'b00) nresp++;
        end
        bus.req = 2'b00;
        if (nresp < 4) timeout("rr_resp_wait");

        for (int i = 0; i < 16; i++) do_txn(tbl[i]);

        // Abandon a division mid-CALC with an asynchronous reset.
        @(negedge clk);
        bus.dividend0 = 32'sd100;
        bus.divisor0  = 32'sd7;
        bus.req       = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = (bus.ack != 2'b00);
        end
        if (!got) timeout("abort_ack_wait");
        bus.req = 2'b00;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", {30'b0, bus.ack}, 32'd0);
        chk("arst_resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_q", bus.q, 32'd0);
        chk("arst_r", bus.r, 32'd0);
        chk("arst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // last_grant is back to 1, so requester 0 wins contention again.
        v = '{2'b11, 1'b0, -1000, 33, -30, -10, 1'b0};
        do_txn(v);
        v = '{2'b10, 1'b1, 99999, -100, -999, 99, 1'b0};
        do_txn(v);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
